// File: rtl/answer_checker_if.sv
// Player-facing signal bundle for answer_checker: game/timebase inputs and buttons in,
// window, guess and scoring status out.
interface answer_checker_if;
    logic       tick1Hz;
    logic       answerSig;
    logic [7:0] numSpecial;
    logic       btnUp;
    logic       btnDown;
    logic       btnSubmit;
    logic       answerActive;
    logic [7:0] guess;
    logic [7:0] secsLeft;
    logic       resultValid;
    logic       correct;
    logic       timedOut;
    logic [7:0] score;
    logic [7:0] rounds;

    modport master (
        output tick1Hz, answerSig, numSpecial, btnUp, btnDown, btnSubmit,
        input  answerActive, guess, secsLeft, resultValid, correct, timedOut, score, rounds
    );

    modport slave (
        input  tick1Hz, answerSig, numSpecial, btnUp, btnDown, btnSubmit,
        output answerActive, guess, secsLeft, resultValid, correct, timedOut, score, rounds
    );
endinterface

// File: rtl/answer_checker.sv
// Timed answer window: the player steers a guess with up/down edges and submits it; the
// block grades it against the special-symbol count and keeps score/round totals.
module answer_checker #(
    parameter int ANSWER_SECS = 10,
    parameter int RESULT_SECS = 3,
    parameter int MAX_GUESS   = 99
) (
    input  logic            Clk100M,
    input  logic            Reset,
    answer_checker_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ANSWER, RESULT} state_t;

    localparam logic [7:0] ANS_L  = 8'(ANSWER_SECS);
    localparam logic [7:0] RES_L  = 8'(RESULT_SECS);
    localparam logic [7:0] GMAX_L = 8'(MAX_GUESS);
    localparam logic [7:0] CMAX_L = 8'hFF;

    state_t     state_q, state_d;
    logic [7:0] target_q, target_d;
    logic [7:0] guess_q, guess_d;
    logic [7:0] secs_q, secs_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] score_q, score_d;
    logic [7:0] rounds_q, rounds_d;
    logic       correct_q, correct_d;
    logic       timedout_q, timedout_d;
    logic       resval_q, resval_d;
    logic       up_q, dn_q, sub_q;

    logic up_edge, dn_edge, sub_edge;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim) ? lim : v + 8'd1;
    endfunction

    function automatic logic [7:0] sat_dec(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

    assign up_edge  = bus.btnUp     & ~up_q;
    assign dn_edge  = bus.btnDown   & ~dn_q;
    assign sub_edge = bus.btnSubmit & ~sub_q;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        guess_d    = guess_q;
        secs_d     = secs_q;
        hold_d     = hold_q;
        score_d    = score_q;
        rounds_d   = rounds_q;
        correct_d  = correct_q;
        timedout_d = timedout_q;
        resval_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.answerSig) begin
                    target_d   = bus.numSpecial;
                    guess_d    = 8'd0;
                    secs_d     = ANS_L;
                    correct_d  = 1'b0;
                    timedout_d = 1'b0;
                    state_d    = ANSWER;
                end
            end

            ANSWER: begin
                // Submit outranks a same-cycle timeout and any same-cycle guess edit.
                if (sub_edge) begin
                    correct_d = (guess_q == target_q);
                    if (guess_q == target_q) score_d = sat_inc(score_q, CMAX_L);
                    rounds_d  = sat_inc(rounds_q, CMAX_L);
                    hold_d    = RES_L;
                    resval_d  = 1'b1;
                    state_d   = RESULT;
                end else if (bus.tick1Hz && secs_q == 8'd1) begin
                    secs_d     = 8'd0;
                    timedout_d = 1'b1;
                    correct_d  = 1'b0;
                    rounds_d   = sat_inc(rounds_q, CMAX_L);
                    hold_d     = RES_L;
                    resval_d   = 1'b1;
                    state_d    = RESULT;
                end else begin
                    if (bus.tick1Hz) secs_d = secs_q - 8'd1;
                    if (up_edge && !dn_edge)      guess_d = sat_inc(guess_q, GMAX_L);
                    else if (dn_edge && !up_edge) guess_d = sat_dec(guess_q);
                end
            end

            RESULT: begin
                if (bus.tick1Hz) begin
                    if (hold_q <= 8'd1) begin
                        hold_d  = 8'd0;
                        state_d = IDLE;
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            state_q    <= IDLE;
            target_q   <= 8'd0;
            guess_q    <= 8'd0;
            secs_q     <= 8'd0;
            hold_q     <= 8'd0;
            score_q    <= 8'd0;
            rounds_q   <= 8'd0;
            correct_q  <= 1'b0;
            timedout_q <= 1'b0;
            resval_q   <= 1'b0;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
            sub_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            guess_q    <= guess_d;
            secs_q     <= secs_d;
            hold_q     <= hold_d;
            score_q    <= score_d;
            rounds_q   <= rounds_d;
            correct_q  <= correct_d;
            timedout_q <= timedout_d;
            resval_q   <= resval_d;
            up_q       <= bus.btnUp;
            dn_q       <= bus.btnDown;
            sub_q      <= bus.btnSubmit;
        end
    end

    assign bus.answerActive = (state_q == ANSWER);
    assign bus.guess        = guess_q;
    assign bus.secsLeft     = secs_q;
    assign bus.resultValid  = resval_q;
    assign bus.correct      = correct_q;
    assign bus.timedOut     = timedout_q;
    assign bus.score        = score_q;
    assign bus.rounds       = rounds_q;

endmodule

// File: tb/tb_answer_checker.sv
// Directed bench for answer_checker: expected round results are queued as stimulus is
// issued and graded by a monitor whenever resultValid pulses.
module tb_answer_checker;

    logic Clk100M = 1'b0;
    logic Reset   = 1'b1;

    answer_checker_if bus();

    answer_checker #(
        .ANSWER_SECS(10),
        .RESULT_SECS(3),
        .MAX_GUESS  (99)
    ) dut (
        .Clk100M(Clk100M),
        .Reset  (Reset),
        .bus    (bus)
    );

    always #5 Clk100M = ~Clk100M;

    typedef struct {
        logic       c;
        logic       t;
        logic [7:0] g;
        logic [7:0] s;
        logic [7:0] r;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk100M);
        #1;
    endtask

    task automatic tick();
        bus.tick1Hz = 1'b1;
        step();
        bus.tick1Hz = 1'b0;
    endtask

    task automatic press(input logic u, input logic d, input logic s);
        bus.btnUp     = u;
        bus.btnDown   = d;
        bus.btnSubmit = s;
        step();
        bus.btnUp     = 1'b0;
        bus.btnDown   = 1'b0;
        bus.btnSubmit = 1'b0;
        step();
    endtask

    task automatic start_round(input logic [7:0] n);
        bus.answerSig  = 1'b1;
        bus.numSpecial = n;
        step();
        bus.answerSig  = 1'b0;
        bus.numSpecial = 8'd0;
    endtask

    task automatic expect_res(input logic c, input logic t, input int g, input int s, input int r);
        exp_t e;
        e.c = c;
        e.t = t;
        e.g = 8'(g);
        e.s = 8'(s);
        e.r = 8'(r);
        sb.push_back(e);
    endtask

    // Monitor: every resultValid pulse must match the oldest queued expectation.
    always @(negedge Clk100M) begin
        if (!Reset && bus.resultValid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resultValid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_correct",  int'(bus.correct),  int'(e.c));
                chk("res_timedOut", int'(bus.timedOut), int'(e.t));
                chk("res_guess",    int'(bus.guess),    int'(e.g));
                chk("res_score",    int'(bus.score),    int'(e.s));
                chk("res_rounds",   int'(bus.rounds),   int'(e.r));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tick1Hz    = 1'b0;
        bus.answerSig  = 1'b0;
        bus.numSpecial = 8'd0;
        bus.btnUp      = 1'b1;
        bus.btnDown    = 1'b0;
        bus.btnSubmit  = 1'b0;
        Reset          = 1'b1;
        repeat (3) step();

        chk("rst_guess",        int'(bus.guess),        0);
        chk("rst_secsLeft",     int'(bus.secsLeft),     0);
        chk("rst_score",        int'(bus.score),        0);
        chk("rst_rounds",       int'(bus.rounds),       0);
        chk("rst_answerActive", int'(bus.answerActive), 0);
        chk("rst_resultValid",  int'(bus.resultValid),  0);
        chk("rst_correct",      int'(bus.correct),      0);
        chk("rst_timedOut",     int'(bus.timedOut),     0);

        // btnUp held through reset release: the edge lands in IDLE and is dropped.
        Reset = 1'b0;
        repeat (2) step();
        bus.btnUp = 1'b0;
        step();
        chk("held_up_idle_guess",  int'(bus.guess),        0);
        chk("held_up_idle_active", int'(bus.answerActive), 0);

        // Round 1: target 5, correct answer.
        start_round(8'd5);
        chk("r1_active",   int'(bus.answerActive), 1);
        chk("r1_secsLeft", int'(bus.secsLeft),     10);
        chk("r1_guess",    int'(bus.guess),        0);
        start_round(8'd9);
        repeat (5) press(1'b1, 1'b0, 1'b0);
        chk("r1_guess5", int'(bus.guess), 5);
        expect_res(1'b1, 1'b0, 5, 1, 1);
        press(1'b0, 1'b0, 1'b1);
        chk("r1_active_after", int'(bus.answerActive), 0);
        repeat (2) tick();
        start_round(8'd1);
        chk("r1_sig_ignored_in_result", int'(bus.answerActive), 0);
        tick();

        // Round 2: target 3, saturation, simultaneous buttons, then timeout.
        start_round(8'd3);
        chk("r2_active", int'(bus.answerActive), 1);
        repeat (2) press(1'b0, 1'b1, 1'b0);
        chk("r2_down_sat", int'(bus.guess), 0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        chk("r2_up_down_same", int'(bus.guess), 1);
        repeat (101) press(1'b1, 1'b0, 1'b0);
        chk("r2_up_sat", int'(bus.guess), 99);
        repeat (9) tick();
        chk("r2_secs1",   int'(bus.secsLeft),     1);
        chk("r2_active9", int'(bus.answerActive), 1);
        expect_res(1'b0, 1'b1, 99, 1, 2);
        tick();
        chk("r2_secs0",  int'(bus.secsLeft), 0);
        chk("r2_to_hold", int'(bus.timedOut), 1);
        repeat (3) tick();

        // Round 3: target 2, submit arrives with the final tick.
        start_round(8'd2);
        chk("r3_timedOut_cleared", int'(bus.timedOut), 0);
        repeat (2) press(1'b1, 1'b0, 1'b0);
        repeat (9) tick();
        expect_res(1'b1, 1'b0, 2, 2, 3);
        bus.btnSubmit = 1'b1;
        bus.tick1Hz   = 1'b1;
        step();
        bus.btnSubmit = 1'b0;
        bus.tick1Hz   = 1'b0;
        step();
        chk("r3_secs_kept", int'(bus.secsLeft), 1);
        repeat (3) tick();

        // Round 4: target 2, submit and up together.
        start_round(8'd2);
        repeat (2) press(1'b1, 1'b0, 1'b0);
        expect_res(1'b1, 1'b0, 2, 3, 4);
        press(1'b1, 1'b0, 1'b1);
        chk("r4_guess_held", int'(bus.guess), 2);
        repeat (3) tick();

        // Round 5: target 7, wrong answer.
        start_round(8'd7);
        press(1'b1, 1'b0, 1'b0);
        expect_res(1'b0, 1'b0, 1, 3, 5);
        press(1'b0, 1'b0, 1'b1);
        repeat (3) tick();

        // Round 6: reset mid-answer discards the round.
        start_round(8'd4);
        press(1'b1, 1'b0, 1'b0);
        chk("r6_guess", int'(bus.guess), 1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("r6_active",  int'(bus.answerActive), 0);
        chk("r6_score",   int'(bus.score),        0);
        chk("r6_rounds",  int'(bus.rounds),       0);
        chk("r6_guess0",  int'(bus.guess),        0);
        chk("r6_correct", int'(bus.correct),      0);
        repeat (3) step();

        chk("sb_pending", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
